// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   One-entry registered decode stage for the RV32I integer ALU subset
//   (ADD/SUB/XOR/OR/AND/SLT and their immediate forms). Anything else is
//   flagged illegal, zeroed, and counted in a saturating counter.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake (in_ready is combinational)
//   instr              32-bit instruction word
//   out_valid/out_ready downstream handshake
//   opcode_alu         5-bit ALU op (0 = none)
//   rs1, rs2, rd       register indices
//   imm, use_imm       sign-extended I-type immediate, B-operand select
//   illegal            entry was not decodable to an ALU op
//   illegal_count      saturating count of accepted illegal instructions
module alu_decode_stage #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       opcode_alu,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [31:0]      imm,
   output logic             use_imm,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_count
);

   localparam logic [4:0] OP_NONE = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_XOR  = 5'b00011;
   localparam logic [4:0] OP_OR   = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_SLT  = 5'b01001;

   typedef struct packed {
      logic [4:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_imm;
      logic        illegal;
   } dec_t;

   dec_t             dec_d, dec_q;
   logic             vld_q;
   logic             accept;
   logic [CNT_W-1:0] cnt_q;
   logic [4:0]       alu_op;   // op from funct3 alone, shared by R and I forms

   wire [6:0] opc    = instr[6:0];
   wire [2:0] funct3 = instr[14:12];
   wire [6:0] funct7 = instr[31:25];

   // A held entry only blocks the stage while the consumer stalls.
   assign in_ready = !vld_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      alu_op = OP_NONE;
      case (funct3)
         3'b000:  alu_op = OP_ADD;
         3'b100:  alu_op = OP_XOR;
         3'b110:  alu_op = OP_OR;
         3'b111:  alu_op = OP_AND;
         3'b010:  alu_op = OP_SLT;
         default: alu_op = OP_NONE;   // shifts and SLTU(I) are not supported
      endcase
   end

   // Illegal entries carry only the illegal flag; every field is zero.
   always_comb begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
      if (opc == 7'b0110011) begin
         if (funct7 == 7'b0000000 && alu_op != OP_NONE) begin
            dec_d.op      = alu_op;
            dec_d.illegal = 1'b0;
         end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            dec_d.op      = OP_SUB;
            dec_d.illegal = 1'b0;
         end
         if (!dec_d.illegal) begin
            dec_d.rd  = instr[11:7];
            dec_d.rs1 = instr[19:15];
            dec_d.rs2 = instr[24:20];
         end
      end else if (opc == 7'b0010011 && alu_op != OP_NONE) begin
         dec_d.op      = alu_op;
         dec_d.illegal = 1'b0;
         dec_d.rd      = instr[11:7];
         dec_d.rs1     = instr[19:15];
         dec_d.imm     = {{20{instr[31]}}, instr[31:20]};
         dec_d.use_imm = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         dec_q <= '0;
      end else if (accept) begin
         vld_q <= 1'b1;
         dec_q <= dec_d;
      end else if (out_ready) begin
         vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (accept && dec_d.illegal && cnt_q != {CNT_W{1'b1}})
         cnt_q <= cnt_q + 1'b1;
   end

   assign out_valid     = vld_q;
   assign opcode_alu    = dec_q.op;
   assign rs1           = dec_q.rs1;
   assign rs2           = dec_q.rs2;
   assign rd            = dec_q.rd;
   assign imm           = dec_q.imm;
   assign use_imm       = dec_q.use_imm;
   assign illegal       = dec_q.illegal;
   assign illegal_count = cnt_q;

endmodule
